fetch_seq_ctrl: RTL and testbench
=================================

FETCH_SEQ_CTRL -- requirements
Module: fetch_seq_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Ports SHALL be as follows:
- CLK, in, 1: clock; all state updates on the rising edge.
- RST, in, 1: reset, asynchronous, active-low.
- imem_req_valid, out, 1: fetch request valid.
- imem_req_ready, in, 1: memory accepts the request.
- imem_req_addr, out, 32: fetch address, word-aligned.
- imem_rsp_valid, in, 1: read data valid.
- imem_rsp_ready, out, 1: controller accepts the read data.
- imem_rsp_data, in, 32: instruction word.
- StallD, in, 1: decode stalled; IF/ID register must hold.
- PCSrcE, in, 1: redirect (taken branch or jump) from execute.
- PCTargetE, in, 32: redirect target.
- InstrF, out, 32: instruction presented to the IF/ID register.
- PCF, out, 32: PC of InstrF.
- PCPlus4F, out, 32: PCF+4.
- ValidF, out, 1: InstrF/PCF/PCPlus4F hold a valid fetched instruction.

Function
REQ-003 The FSM SHALL have three states: S_BOOT, S_REQ and S_WAIT; at most one memory request SHALL be outstanding.
REQ-004 S_BOOT SHALL last exactly one cycle after RST deasserts, then move to S_REQ with fetch_pc = RESET_PC.
REQ-005 In S_REQ, imem_req_valid SHALL be 1 and imem_req_addr SHALL equal fetch_pc; in all other states imem_req_valid SHALL be 0.
REQ-006 The request SHALL be accepted in the cycle imem_req_valid && imem_req_ready; on acceptance the FSM goes to S_WAIT and fetch_pc becomes addr+4 (mod 2^32).
REQ-007 imem_req_addr SHALL remain stable while imem_req_valid=1 and imem_req_ready=0, including across a redirect.
REQ-008 imem_rsp_ready SHALL be 1 only in S_WAIT, and only when (!ValidF || !StallD) or a squash is pending.
REQ-009 On response handshake with no squash, the output registers SHALL update next cycle: InstrF=imem_rsp_data, PCF=request address, PCPlus4F=PCF+4, ValidF=1; the FSM then returns to S_REQ.
REQ-010 The output entry SHALL be consumed in any cycle where ValidF=1 and StallD=0; on consumption without a new capture, ValidF SHALL go to 0 next cycle.
REQ-011 While ValidF=1 and StallD=1, InstrF, PCF, PCPlus4F and ValidF SHALL hold unchanged.
REQ-012 Capture and consumption in the same cycle SHALL replace the entry, leaving ValidF=1.
REQ-013 Zero-wait-state memory throughput SHALL be one instruction per 2 cycles.
REQ-014 PCSrcE=1 SHALL have priority over all other events in that cycle:
- fetch_pc <= {PCTargetE[31:2], 2'b00};
- ValidF <= 0.
REQ-015 Redirect in S_WAIT, or in S_REQ in the same cycle as acceptance, SHALL set the squash flag.
REQ-016 Redirect in S_REQ without acceptance SHALL set squash.
- The held request completes, and its response is dropped.
- The next request then uses the target.
REQ-017 A response arriving while squash=1 SHALL be accepted and discarded with no output update; squash clears and the FSM goes to S_REQ at the redirected fetch_pc.
REQ-018 A redirect in the same cycle as a response SHALL discard that response, with the same behaviour as REQ-017.
REQ-019 A redirect while squash is already 1 SHALL only overwrite fetch_pc; only one response SHALL be discarded.
REQ-020 PC arithmetic SHALL be 32-bit unsigned with wrap-around: 32'hFFFF_FFFC+4 = 32'h0000_0000.

Reset
REQ-021 RST=0 SHALL immediately force the following, regardless of any outstanding request, which is abandoned:
- state S_BOOT, fetch_pc=RESET_PC, squash=0;
- imem_req_valid=0, imem_rsp_ready=0, imem_req_addr=0;
- InstrF=0, PCF=0, PCPlus4F=0, ValidF=0.
REQ-022 A response arriving during or after reset, for a request issued before reset, is outside scope; the memory SHALL be reset together with this block.

Verification
REQ-023 Boot: release RST with ready=1 and a 1-cycle memory -> first request addr 0x0; ValidF rises with PCF=0x0, PCPlus4F=0x4; the next request addr is 0x4.
REQ-024 Backpressure: imem_req_ready=0 for 3 cycles at addr 0x8 -> addr holds 0x8 with valid=1 throughout; a single acceptance follows.
REQ-025 Decode stall: StallD=1 for 4 cycles with ValidF=1 (PCF=0x10) -> outputs frozen and imem_rsp_ready=0 on a pending response; the next instruction (PCF=0x14) follows release.
REQ-026 Redirect in S_WAIT: PCSrcE=1, PCTargetE=0x103 -> ValidF=0; the in-flight response is dropped; the next request addr is 0x100 and ValidF returns with PCF=0x100.
REQ-027 Simultaneous response and redirect to 0x40 -> no output update; the next request addr is 0x40.
REQ-028 Reset mid-fetch: assert RST in S_WAIT -> all outputs 0 in the same cycle; after release, refetch starts at RESET_PC.

Source files
------------

// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl: single-outstanding instruction fetch sequencer with
// decode-stall hold and execute-redirect squash of the in-flight response.
module fetch_seq_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   output logic        imem_rsp_ready,
   input  logic [31:0] imem_rsp_data,
   input  logic        StallD,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic [31:0] InstrF,
   output logic [31:0] PCF,
   output logic [31:0] PCPlus4F,
   output logic        ValidF
);
   typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT} state_t;
   state_t state, state_n;
   logic [31:0] fetch_pc, fetch_pc_n, req_pc, req_pc_n, tgt;
   logic squash, squash_n, accept, rsp_fire, capture, valid_n;
   assign tgt = {PCTargetE[31:2], 2'b00};
   always_comb begin
      state_n = state;
      fetch_pc_n = fetch_pc;
      req_pc_n = req_pc;
      squash_n = squash;
      imem_req_valid = state == S_REQ;
      imem_req_addr = imem_req_valid ? req_pc : '0;
      imem_rsp_ready = (state == S_WAIT) && (!ValidF || !StallD || squash || PCSrcE);
      accept = imem_req_valid && imem_req_ready;
      rsp_fire = imem_rsp_ready && imem_rsp_valid;
      capture = rsp_fire && !squash && !PCSrcE;
      case (state)
         S_BOOT: begin
            state_n = S_REQ;
            req_pc_n = PCSrcE ? tgt : fetch_pc;
         end
         S_REQ: begin
            // req_pc stays put until accepted; a redirect only retargets fetch_pc
            state_n = accept ? S_WAIT : S_REQ;
            fetch_pc_n = (accept && !squash) ? req_pc + 32'd4 : fetch_pc;
            squash_n = squash || PCSrcE;
         end
         S_WAIT: begin
            state_n = rsp_fire ? S_REQ : S_WAIT;
            req_pc_n = rsp_fire ? (PCSrcE ? tgt : fetch_pc) : req_pc;
            squash_n = rsp_fire ? 1'b0 : (squash || PCSrcE);
         end
         default: state_n = S_BOOT;
      endcase
      fetch_pc_n = PCSrcE ? tgt : fetch_pc_n;
      valid_n = PCSrcE ? 1'b0 : capture ? 1'b1 : (ValidF && !StallD) ? 1'b0 : ValidF;
   end
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= S_BOOT;
         fetch_pc <= RESET_PC;
         req_pc <= '0;
         squash <= 1'b0;
         InstrF <= '0;
         PCF <= '0;
         PCPlus4F <= '0;
         ValidF <= 1'b0;
      end else begin
         state <= state_n;
         fetch_pc <= fetch_pc_n;
         req_pc <= req_pc_n;
         squash <= squash_n;
         ValidF <= valid_n;
         if (capture) begin
            InstrF <= imem_rsp_data;
            PCF <= req_pc;
            PCPlus4F <= req_pc + 32'd4;
         end
      end
   end
endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb_fetch_seq_ctrl: cycle-by-cycle directed vectors with the bench acting as memory.
module tb_fetch_seq_ctrl;
   logic CLK = 1'b0, RST = 1'b0;
   logic imem_req_valid, imem_req_ready, imem_rsp_valid, imem_rsp_ready, StallD, PCSrcE, ValidF;
   logic [31:0] imem_req_addr, imem_rsp_data, PCTargetE, InstrF, PCF, PCPlus4F;
   int n_vec = 0, n_bad = 0;

   fetch_seq_ctrl dut (
      .CLK(CLK), .RST(RST),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready), .imem_rsp_data(imem_rsp_data),
      .StallD(StallD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic rr, rv; logic [31:0] rd; logic st, ps; logic [31:0] tg;
      logic qv; logic [31:0] qa; logic sr, vf; logic [31:0] pc, ins;
   } vec_t;

   function automatic vec_t mk(logic rr, logic rv, logic [31:0] rd, logic st, logic ps, logic [31:0] tg,
                               logic qv, logic [31:0] qa, logic sr, logic vf, logic [31:0] pc, logic [31:0] ins);
      vec_t v;
      v.rr = rr; v.rv = rv; v.rd = rd; v.st = st; v.ps = ps; v.tg = tg;
      v.qv = qv; v.qa = qa; v.sr = sr; v.vf = vf; v.pc = pc; v.ins = ins;
      return v;
   endfunction

   // drive at a negedge, check 1 time unit later, return at the next negedge
   task automatic apply(input vec_t v, input string nm);
      logic [31:0] ep4;
      logic [130:0] act, exp;
      imem_req_ready = v.rr; imem_rsp_valid = v.rv; imem_rsp_data = v.rd;
      StallD = v.st; PCSrcE = v.ps; PCTargetE = v.tg;
      #1;
      ep4 = (v.pc == 0 && v.ins == 0) ? 32'd0 : v.pc + 32'd4;
      act = {imem_req_valid, imem_req_addr, imem_rsp_ready, ValidF, PCF, InstrF, PCPlus4F};
      exp = {v.qv, v.qa, v.sr, v.vf, v.pc, v.ins, ep4};
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got qv=%b qa=%h sr=%b vf=%b pc=%h ins=%h p4=%h want qv=%b qa=%h sr=%b vf=%b pc=%h ins=%h p4=%h",
                  nm, imem_req_valid, imem_req_addr, imem_rsp_ready, ValidF, PCF, InstrF, PCPlus4F,
                  v.qv, v.qa, v.sr, v.vf, v.pc, v.ins, ep4);
      end
      @(negedge CLK);
   endtask

   task automatic check_reset(input string nm);
      n_vec++;
      if ({imem_req_valid, imem_req_addr, imem_rsp_ready, ValidF, PCF, InstrF, PCPlus4F} !== '0) begin
         n_bad++;
         $display("FAIL %s: got qv=%b qa=%h sr=%b vf=%b pc=%h ins=%h p4=%h want all zero",
                  nm, imem_req_valid, imem_req_addr, imem_rsp_ready, ValidF, PCF, InstrF, PCPlus4F);
      end
   endtask

   vec_t tbl[$];
   localparam logic [31:0] A0 = 32'hA000_0001, A1 = 32'hA100_0002, A2 = 32'hA200_0003, A3 = 32'hA300_0004,
                           A4 = 32'hA400_0005, A5 = 32'hA500_0006, B0 = 32'hB000_0007, B1 = 32'hB100_0008,
                           B2 = 32'hB200_0009, C0 = 32'hC000_000A, BAD = 32'hDEAD_BEEF;

   initial begin
      imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; StallD = 0; PCSrcE = 0; PCTargetE = 0;
      // boot and steady-state fetch
      tbl.push_back(mk(1,0,0  ,0,0,0, 0,0,0,0,0,0));
      tbl.push_back(mk(1,0,0  ,0,0,0, 1,0,0,0,0,0));
      tbl.push_back(mk(1,1,A0 ,0,0,0, 0,0,1,0,0,0));
      tbl.push_back(mk(1,0,0  ,0,0,0, 1,4,0,1,0,A0));
      tbl.push_back(mk(1,1,A1 ,0,0,0, 0,0,1,0,0,A0));
      // request backpressure at 0x8
      tbl.push_back(mk(0,0,0  ,0,0,0, 1,8,0,1,4,A1));
      tbl.push_back(mk(0,0,0  ,0,0,0, 1,8,0,0,4,A1));
      tbl.push_back(mk(0,0,0  ,0,0,0, 1,8,0,0,4,A1));
      tbl.push_back(mk(1,0,0  ,0,0,0, 1,8,0,0,4,A1));
      tbl.push_back(mk(1,1,A2 ,0,0,0, 0,0,1,0,4,A1));
      tbl.push_back(mk(1,0,0  ,0,0,0, 1,32'hC,0,1,8,A2));
      tbl.push_back(mk(1,1,A3 ,0,0,0, 0,0,1,0,8,A2));
      tbl.push_back(mk(1,0,0  ,0,0,0, 1,32'h10,0,1,32'hC,A3));
      tbl.push_back(mk(1,1,A4 ,0,0,0, 0,0,1,0,32'hC,A3));
      // decode stall for 4 cycles holding PCF=0x10
      tbl.push_back(mk(1,0,0  ,1,0,0, 1,32'h14,0,1,32'h10,A4));
      tbl.push_back(mk(1,1,A5 ,1,0,0, 0,0,0,1,32'h10,A4));
      tbl.push_back(mk(1,1,A5 ,1,0,0, 0,0,0,1,32'h10,A4));
      tbl.push_back(mk(1,1,A5 ,1,0,0, 0,0,0,1,32'h10,A4));
      tbl.push_back(mk(1,1,A5 ,0,0,0, 0,0,1,1,32'h10,A4));
      tbl.push_back(mk(1,0,0  ,0,0,0, 1,32'h18,0,1,32'h14,A5));
      // redirect in S_WAIT, then again while squash pending
      tbl.push_back(mk(1,0,0  ,0,1,32'h103, 0,0,1,0,32'h14,A5));
      tbl.push_back(mk(1,0,0  ,0,1,32'h120, 0,0,1,0,32'h14,A5));
      tbl.push_back(mk(1,1,BAD,0,0,0, 0,0,1,0,32'h14,A5));
      tbl.push_back(mk(1,0,0  ,0,0,0, 1,32'h120,0,0,32'h14,A5));
      tbl.push_back(mk(1,1,B0 ,0,0,0, 0,0,1,0,32'h14,A5));
      tbl.push_back(mk(1,0,0  ,0,0,0, 1,32'h124,0,1,32'h120,B0));
      // response and redirect to 0x40 together
      tbl.push_back(mk(1,1,BAD,0,1,32'h40, 0,0,1,0,32'h120,B0));
      tbl.push_back(mk(1,0,0  ,0,0,0, 1,32'h40,0,0,32'h120,B0));
      tbl.push_back(mk(1,1,B1 ,0,0,0, 0,0,1,0,32'h120,B0));
      // redirect in S_REQ while not accepted: address holds, response dropped
      tbl.push_back(mk(0,0,0  ,0,1,32'h200, 1,32'h44,0,1,32'h40,B1));
      tbl.push_back(mk(1,0,0  ,0,0,0, 1,32'h44,0,0,32'h40,B1));
      tbl.push_back(mk(1,1,BAD,0,0,0, 0,0,1,0,32'h40,B1));
      tbl.push_back(mk(1,0,0  ,0,0,0, 1,32'h200,0,0,32'h40,B1));
      tbl.push_back(mk(1,1,B2 ,0,0,0, 0,0,1,0,32'h40,B1));
      // redirect coinciding with acceptance, target wraps the PC
      tbl.push_back(mk(0,0,0  ,1,0,0, 1,32'h204,0,1,32'h200,B2));
      tbl.push_back(mk(1,0,0  ,0,1,32'hFFFF_FFFF, 1,32'h204,0,1,32'h200,B2));
      tbl.push_back(mk(1,1,BAD,0,0,0, 0,0,1,0,32'h200,B2));
      tbl.push_back(mk(1,0,0  ,0,0,0, 1,32'hFFFF_FFFC,0,0,32'h200,B2));
      tbl.push_back(mk(1,1,C0 ,0,0,0, 0,0,1,0,32'h200,B2));
      tbl.push_back(mk(1,0,0  ,0,0,0, 1,32'h0,0,1,32'hFFFF_FFFC,C0));
      tbl.push_back(mk(1,0,0  ,0,0,0, 0,0,1,0,32'hFFFF_FFFC,C0));

      repeat (2) @(negedge CLK);
      #1 check_reset("reset_hold");
      @(negedge CLK);
      RST = 1'b1;
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

      // reset while a request is outstanding
      RST = 1'b0;
      #1 check_reset("reset_mid_fetch");
      @(negedge CLK);
      RST = 1'b1;
      apply(mk(1,0,0,0,0,0, 0,0,0,0,0,0), "reboot_boot");
      apply(mk(1,0,0,0,0,0, 1,0,0,0,0,0), "reboot_req");
      apply(mk(1,1,A0,0,0,0, 0,0,1,0,0,0), "reboot_wait");
      apply(mk(1,0,0,0,0,0, 1,4,0,1,0,A0), "reboot_capture");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
